// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller that owns the single 8-bit RAM port.
// It serves instruction fetches (IF) and load/store requests (MEM) and
// assembles or splits 32-bit words little-endian, one byte per RAM access.
// A completed access is reported with a one-cycle done pulse to its owner.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/addr/flush_IF_i   fetch request, byte address, abandon-fetch
//   if_inst_IF_o/done_IF_o   fetched word, one-cycle completion pulse
//   mem_req/we/len/addr/wdata_MEM_i  load/store request (len 00 B, 01 H, 1x W)
//   mem_rdata_MEM_o/done_MEM_o       zero-extended load data, completion pulse
//   busy_STALLER_o           high whenever not IDLE
//   ram_addr/wdata/wr_RAM_o  RAM byte address, write byte, write strobe
//   ram_data_RAM_i           RAM read byte, captured RD_LAT cycles after address
module mem_ctrl #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_IF_i,
  input  logic [31:0] if_addr_IF_i,
  input  logic        if_flush_IF_i,
  output logic [31:0] if_inst_IF_o,
  output logic        if_done_IF_o,
  input  logic        mem_req_MEM_i,
  input  logic        mem_we_MEM_i,
  input  logic [1:0]  mem_len_MEM_i,
  input  logic [31:0] mem_addr_MEM_i,
  input  logic [31:0] mem_wdata_MEM_i,
  output logic [31:0] mem_rdata_MEM_o,
  output logic        mem_done_MEM_o,
  output logic        busy_STALLER_o,
  output logic [31:0] ram_addr_RAM_o,
  output logic [7:0]  ram_wdata_RAM_o,
  output logic        ram_wr_RAM_o,
  input  logic [7:0]  ram_data_RAM_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  state_t      state;
  logic        own_mem;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf;
  logic [1:0]  k;
  logic [1:0]  last_k;
  logic [3:0]  wcnt;

  logic [1:0]  k_nxt;
  logic [31:0] word_nxt;

  // Result word with the byte currently on the RAM bus merged into slot k;
  // used both for the running buffer and for the final output update.
  always_comb begin
    k_nxt    = k + 2'd1;
    word_nxt = rbuf;
    word_nxt[8*k +: 8] = ram_data_RAM_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      own_mem         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rbuf            <= '0;
      k               <= '0;
      last_k          <= '0;
      wcnt            <= '0;
      if_inst_IF_o    <= '0;
      if_done_IF_o    <= 1'b0;
      mem_rdata_MEM_o <= '0;
      mem_done_MEM_o  <= 1'b0;
      busy_STALLER_o  <= 1'b0;
      ram_addr_RAM_o  <= '0;
      ram_wdata_RAM_o <= '0;
      ram_wr_RAM_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k    <= '0;
          wcnt <= '0;
          rbuf <= '0;
          if (mem_req_MEM_i) begin
            own_mem        <= 1'b1;
            addr_q         <= mem_addr_MEM_i;
            wdata_q        <= mem_wdata_MEM_i;
            last_k         <= (mem_len_MEM_i == 2'b00) ? 2'd0 :
                              (mem_len_MEM_i == 2'b01) ? 2'd1 : 2'd3;
            ram_addr_RAM_o <= mem_addr_MEM_i;
            busy_STALLER_o <= 1'b1;
            if (mem_we_MEM_i) begin
              state           <= WR;
              ram_wr_RAM_o    <= 1'b1;
              ram_wdata_RAM_o <= mem_wdata_MEM_i[7:0];
            end else begin
              state <= RD;
            end
          end else if (if_req_IF_i && !if_flush_IF_i) begin
            own_mem        <= 1'b0;
            addr_q         <= if_addr_IF_i;
            last_k         <= 2'd3;
            ram_addr_RAM_o <= if_addr_IF_i;
            busy_STALLER_o <= 1'b1;
            state          <= RD;
          end
        end

        RD: begin
          if (!own_mem && if_flush_IF_i) begin
            state          <= IDLE;
            busy_STALLER_o <= 1'b0;
          end else if (wcnt == LAT_M1) begin
            rbuf <= word_nxt;
            if (k == last_k) begin
              state <= DONE;
              if (own_mem) begin
                mem_rdata_MEM_o <= word_nxt;
                mem_done_MEM_o  <= 1'b1;
              end else begin
                if_inst_IF_o <= word_nxt;
                if_done_IF_o <= 1'b1;
              end
            end else begin
              k              <= k_nxt;
              wcnt           <= '0;
              ram_addr_RAM_o <= addr_q + {30'b0, k_nxt};
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end

        WR: begin
          if (k == last_k) begin
            state          <= DONE;
            ram_wr_RAM_o   <= 1'b0;
            mem_done_MEM_o <= 1'b1;
          end else begin
            k               <= k_nxt;
            ram_addr_RAM_o  <= addr_q + {30'b0, k_nxt};
            ram_wdata_RAM_o <= wdata_q[8*k_nxt +: 8];
          end
        end

        DONE: begin
          if_done_IF_o   <= 1'b0;
          mem_done_MEM_o <= 1'b0;
          busy_STALLER_o <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, busy;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata, ram_data;
  logic        ram_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req_IF_i(if_req), .if_addr_IF_i(if_addr), .if_flush_IF_i(if_flush),
    .if_inst_IF_o(if_inst), .if_done_IF_o(if_done),
    .mem_req_MEM_i(mem_req), .mem_we_MEM_i(mem_we), .mem_len_MEM_i(mem_len),
    .mem_addr_MEM_i(mem_addr), .mem_wdata_MEM_i(mem_wdata),
    .mem_rdata_MEM_o(mem_rdata), .mem_done_MEM_o(mem_done),
    .busy_STALLER_o(busy),
    .ram_addr_RAM_o(ram_addr), .ram_wdata_RAM_o(ram_wdata), .ram_wr_RAM_o(ram_wr),
    .ram_data_RAM_i(ram_data)
  );

  // RAM model: 1 KiB (address bits [9:0]); unwritten bytes return preset image.
  logic [7:0] ram [1024];
  logic       ram_v [1024];
  logic       ram_clr;

  function automatic logic [7:0] init_byte(input logic [9:0] a);
    case (a)
      10'h100: return 8'h13;
      10'h101: return 8'h05;
      10'h3FF: return 8'h77;
      10'h000: return 8'h88;
      10'h040: return 8'h01;
      10'h041: return 8'h02;
      10'h042: return 8'h03;
      10'h043: return 8'h04;
      10'h080: return 8'h93;
      10'h082: return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram_v[i] <= 1'b0;
    end else if (ram_wr) begin
      ram[ram_addr[9:0]]   <= ram_wdata;
      ram_v[ram_addr[9:0]] <= 1'b1;
    end
  end

  assign ram_data = ram_v[ram_addr[9:0]] ? ram[ram_addr[9:0]] : init_byte(ram_addr[9:0]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mem_op(input logic we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mem_done) begin lat = c; break; end
    end
    rd = mem_rdata;
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] inst, output int lat);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (if_done) begin lat = c; break; end
    end
    inst = if_inst;
    if_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd, wv;
    int lat, md, id, wcount, dcount;

    rst = 1'b0; ram_clr = 1'b1;
    if_req = 0; if_flush = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_len = '0; mem_addr = '0; mem_wdata = '0;

    // {we, len, addr, wdata, expected rdata (loads), expected done latency}
    vecs[0]  = '{1'b1, 2'b10, 32'h20,       32'hDEADBEEF, 32'h0,        5};
    vecs[1]  = '{1'b0, 2'b00, 32'h22,       32'h0,        32'h000000AD, 3};
    vecs[2]  = '{1'b0, 2'b10, 32'h20,       32'h0,        32'hDEADBEEF, 9};
    vecs[3]  = '{1'b0, 2'b01, 32'h21,       32'h0,        32'h0000ADBE, 5};
    vecs[4]  = '{1'b1, 2'b01, 32'h30,       32'hAAAA1234, 32'h0,        3};
    vecs[5]  = '{1'b0, 2'b11, 32'h30,       32'h0,        32'h00001234, 9};
    vecs[6]  = '{1'b1, 2'b00, 32'h31,       32'hFFFFFF5A, 32'h0,        2};
    vecs[7]  = '{1'b0, 2'b10, 32'h30,       32'h0,        32'h00005A34, 9};
    vecs[8]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'h0,        32'h00008877, 5};
    vecs[9]  = '{1'b1, 2'b10, 32'hFFFFFFFE, 32'h11223344, 32'h0,        5};
    vecs[10] = '{1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h11223344, 9};

    #1;
    chk("reset_outputs", {30'b0, ram_wr, busy} | ram_addr | {24'b0, ram_wdata} |
        if_inst | mem_rdata | {31'b0, if_done | mem_done}, 32'h0);
    repeat (3) @(negedge clk);
    ram_clr = 1'b0; rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      mem_op(vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Word fetch at 0x100: each address held two cycles, done after E0+8,
    // request held through DONE must not be re-accepted there.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if_done) begin lat = c; break; end
      if (c <= 8) chk($sformatf("fetch_addr_c%0d", c), ram_addr, 32'h100 + 32'((c - 1) / 2));
    end
    chk("fetch_latency", 32'(lat), 32'd9);
    chk("fetch_inst", if_inst, 32'h00000513);
    @(negedge clk);
    chk("no_accept_in_done", {30'b0, busy, if_done}, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    chk("idle_after_fetch", {31'b0, busy}, 32'h0);

    // Simultaneous requests: MEM store first, then the IF fetch.
    @(negedge clk);
    wv = 32'hCAFEF00D;
    mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h50; mem_wdata = wv;
    if_req = 1; if_addr = 32'h100;
    md = -1; id = -1; wcount = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ram_wr) wcount++;
      if (c <= 4) begin
        chk($sformatf("st_wr_c%0d", c), {31'b0, ram_wr}, 32'h1);
        chk($sformatf("st_addr_c%0d", c), ram_addr, 32'h50 + 32'(c - 1));
        chk($sformatf("st_byte_c%0d", c), {24'b0, ram_wdata}, {24'b0, wv[8*(c-1) +: 8]});
      end
      if (mem_done) begin md = c; mem_req = 0; end
      if (if_done) begin id = c; if_req = 0; break; end
    end
    chk("prio_mem_latency", 32'(md), 32'd5);
    chk("prio_if_gap", 32'(id - md), 32'd10);
    chk("prio_if_inst", if_inst, 32'h00000513);
    chk("prio_write_cycles", 32'(wcount), 32'd4);
    @(negedge clk);

    // Flush after byte 1 captured: back to IDLE, no done, inst unchanged.
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    repeat (5) @(negedge clk);
    if_flush = 1; if_req = 0;
    @(negedge clk);
    chk("flush_idle", {31'b0, busy}, 32'h0);
    if_flush = 0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (if_done) dcount++;
    end
    chk("flush_no_done", 32'(dcount), 32'h0);
    chk("flush_inst_kept", if_inst, 32'h00000513);
    fetch(32'h80, rd, lat);
    chk("post_flush_latency", 32'(lat), 32'd9);
    chk("post_flush_inst", rd, 32'h00100093);

    // Reset during the second byte of a word store.
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h60; mem_wdata = 32'h55667788;
    repeat (2) @(negedge clk);
    chk("rst_pre_addr", ram_addr, 32'h61);
    rst = 1'b0;
    #1;
    chk("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'h0);
    chk("rst_flags", {29'b0, busy, mem_done, if_done}, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    mem_req = 0;
    @(negedge clk);
    rst = 1'b1;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_done || if_done || busy) dcount++;
    end
    chk("rst_no_done", 32'(dcount), 32'h0);
    mem_op(1'b0, 2'b00, 32'h60, 32'h0, rd, lat);
    chk("rst_next_latency", 32'(lat), 32'd3);
    chk("rst_next_rdata", rd, 32'h00000088);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
